// File: rtl/fetch_pkg.sv
// Shared constants for the fetch front end: data width, PC increment and
// the default architectural reset PC.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h4000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with push, pop, flush, an occupancy count and a
// registered head. DEPTH must be a power of two so the pointers wrap
// naturally. A pop on an empty FIFO is ignored. A push into a full FIFO is
// ignored unless a pop happens in the same cycle. A flush empties the FIFO
// and wins over a push in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; the array carries no reset since count guards validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : fetch_fifo

// File: rtl/fetch_issue.sv
// Fetch issue stage. It owns the fetch PC and issues in-order instruction
// memory reads. It pairs each response with its PC and buffers {pc, inst}
// toward decode. On a redirect it flushes the buffer and drops responses
// to requests issued before the redirect.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. For the request and output channels, valid does not
// depend on the ready of the same channel. Responses have no ready: the
// block always accepts them.
module fetch_issue
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [XLEN-1:0]        imem_resp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_inst,
  output logic [$clog2(DEPTH):0] in_flight
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ONE          = CW'(1);

  logic [XLEN-1:0]   pc;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     buf_count;
  logic [CW-1:0]     in_flight_after_resp;
  logic [CW:0]       credit_used;
  logic [XLEN-1:0]   pcq_head;
  logic [2*XLEN-1:0] buf_head;
  logic              issue;
  logic              resp_pop;
  logic              drop;
  logic              buf_push;
  logic              buf_pop;

  // Credits: buffered entries plus outstanding requests never exceed DEPTH.
  // Space for every response is therefore reserved before its request goes out.
  assign credit_used    = {1'b0, buf_count} + {1'b0, in_flight};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < CREDIT_LIMIT);
  assign imem_req_addr  = pc;
  assign issue          = imem_req_valid && imem_req_ready;

  // A response belongs to a stale stream while drop_cnt is nonzero. It is
  // also stale if a redirect arrives in the same cycle.
  assign resp_pop = imem_resp_valid && (in_flight != '0);
  assign drop     = (drop_cnt != '0) || redirect_valid;
  assign buf_push = resp_pop && !drop;
  assign buf_pop  = out_valid && out_ready;

  // No request is issued in a redirect cycle, so the requests still
  // outstanding after the cycle are the current ones minus any response
  // that arrives now.
  assign in_flight_after_resp = resp_pop ? (in_flight - ONE) : in_flight;

  assign out_valid = (buf_count != '0);
  assign out_pc    = buf_head[2*XLEN-1:XLEN];
  assign out_inst  = buf_head[XLEN-1:0];

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (pc),
    .pop       (resp_pop),
    .flush     (1'b0),
    .count     (in_flight),
    .head      (pcq_head)
  );

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (buf_push),
    .push_data ({pcq_head, imem_resp_data}),
    .pop       (buf_pop),
    .flush     (redirect_valid),
    .count     (buf_count),
    .head      (buf_head)
  );

  // Fetch PC: reset, then redirect target, then sequential advance on issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (issue) begin
      pc <= pc + PC_STEP;
    end
  end

  // Drop counter: a redirect marks every request still outstanding as stale.
  // Each response that arrives while the counter is nonzero consumes one.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= in_flight_after_resp;
    end else if (resp_pop && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - ONE;
    end
  end

  a_resp_tracked : assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (in_flight != '0))
    else $error("fetch_issue: response with no request outstanding");

  a_redirect_aligned : assert property (@(posedge clk) disable iff (rst)
    redirect_valid |-> (redirect_pc[1:0] == 2'b00))
    else $error("fetch_issue: redirect target not word aligned");

endmodule : fetch_issue

// File: tb/tb_fetch_issue.sv
// Randomized bench for fetch_issue. The reference model is stream based.
// Each request carries the epoch that was current when it was accepted.
// Reset and redirect start a new epoch. A response is delivered to decode
// only if its epoch is still current and no redirect occurs in the same cycle.
// Request addresses and consumed PCs must run sequentially from the latest
// reset or redirect target.
module tb_fetch_issue;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam int          DEPTH  = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [31:0]            imem_req_addr;
  logic                   imem_resp_valid;
  logic [31:0]            imem_resp_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_pc;
  logic [31:0]            out_inst;
  logic [$clog2(DEPTH):0] in_flight;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pending[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_req_pc;
  int          epoch;
  int          cyc;
  int          checks;
  int          failures;

  fetch_issue #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .in_flight       (in_flight)
  );

  // Clock
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 32'h4000_0100;
      1:       return 32'hFFFF_FFF8;
      default: return RST_PC + ($urandom_range(0, 1023) << 2);
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: check the registered outputs, drive random inputs,
  // check the request channel, then advance the model at the clock edge.
  task automatic step(input int p_req, input int p_out, input int p_redir,
                      input int max_lat, input bit in_rst);
    bit   exp_req_valid;
    bit   issue;
    bit   resp;
    bit   consume;
    bit   redir;
    req_t r;
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("in_flight", 64'(in_flight), 64'(pending.size()));
    if (exp_q.size() != 0) begin
      check("out_pc",   64'(out_pc),   64'(exp_q[0][63:32]));
      check("out_inst", 64'(out_inst), 64'(exp_q[0][31:0]));
    end

    rst            = in_rst;
    out_ready      = ($urandom_range(0, 99) < p_out);
    imem_req_ready = ($urandom_range(0, 99) < p_req);
    redirect_valid = ($urandom_range(0, 99) < p_redir);
    redirect_pc    = pick_target();
    resp           = !in_rst && (pending.size() != 0) && (pending[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(pending[0].addr) : $urandom;
    redir          = redirect_valid;

    #1;
    exp_req_valid = !in_rst && !redir && ((exp_q.size() + pending.size()) < DEPTH);
    check("req_valid", 64'(imem_req_valid), 64'(exp_req_valid));
    if (exp_req_valid) check("req_addr", 64'(imem_req_addr), 64'(exp_req_pc));
    issue   = exp_req_valid && imem_req_ready;
    consume = (exp_q.size() != 0) && out_ready;

    @(posedge clk);
    if (in_rst) begin
      pending.delete();
      exp_q.delete();
      epoch++;
      exp_req_pc = RST_PC;
    end else begin
      if (consume) void'(exp_q.pop_front());
      if (resp) begin
        r = pending.pop_front();
        if (!redir && (r.epoch == epoch)) exp_q.push_back({r.addr, mem_word(r.addr)});
      end
      if (issue) begin
        r.addr  = exp_req_pc;
        r.epoch = epoch;
        r.due   = cyc + $urandom_range(1, max_lat);
        pending.push_back(r);
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (redir) begin
        exp_q.delete();
        epoch++;
        exp_req_pc = redirect_pc;
      end
    end
    cyc++;
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    cyc             = 0;
    epoch           = 0;
    exp_req_pc      = RST_PC;
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    out_ready       = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held, with redirects that must be ignored
    repeat (3)    step(100, 100, 50, 1, 1'b1);
    // Fill and steady stream, single-cycle memory
    repeat (30)   step(100, 100, 0, 1, 1'b0);
    // Decode stalled: credits must cap issue at DEPTH
    repeat (12)   step(100, 0, 0, 1, 1'b0);
    repeat (20)   step(100, 100, 0, 1, 1'b0);
    // Frequent redirects with requests in flight
    repeat (300)  step(100, 100, 12, 2, 1'b0);
    repeat (200)  step(100, 60, 20, 3, 1'b0);
    // Random ready and 1-3 cycle latency
    repeat (1500) step(60, 70, 5, 3, 1'b0);
    // Reset mid-stream with a full buffer
    repeat (10)   step(100, 0, 0, 1, 1'b0);
    repeat (2)    step(50, 50, 50, 3, 1'b1);
    repeat (30)   step(100, 100, 0, 1, 1'b0);
    // Mixed traffic with occasional resets
    for (int i = 0; i < 6; i++) begin
      repeat (250) step(70, 70, 6, 3, 1'b0);
      step(50, 50, 30, 3, 1'b1);
    end
    repeat (20)   step(100, 100, 0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_issue
